// File: rtl/aes_block_demux.sv
// aes_block_demux: steers one held DATA_W block to output 0 or 1 with valid/ready handshakes.
// Optional per-output delivery counters are built only when AES_DEMUX_CNT_EN is defined.
module aes_block_demux #(
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_sel,
  output logic              in_ready,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic [15:0]       cnt0,
  output logic [15:0]       cnt1
);
  typedef enum logic [1:0] {IDLE, HOLD0, HOLD1} state_t;
  state_t            state_q;
  logic [DATA_W-1:0] data_q;
  logic              in_xfer;
  assign out0_valid = state_q == HOLD0;
  assign out1_valid = state_q == HOLD1;
  assign busy       = state_q != IDLE;
  assign out_data   = data_q;
  assign in_ready   = (state_q == IDLE) || (out0_valid && out0_ready) || (out1_valid && out1_ready);
  assign in_xfer    = in_valid && in_ready;
  // in_ready without a new block means the held block just left (or nothing was held)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
    end else if (in_xfer) begin
      state_q <= in_sel ? HOLD1 : HOLD0;
      data_q  <= in_data;
    end else if (in_ready) begin
      state_q <= IDLE;
    end
  end
`ifdef AES_DEMUX_CNT_EN
  logic [15:0] cnt0_q, cnt1_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (out0_valid && out0_ready) cnt0_q <= cnt0_q + 16'd1;
      if (out1_valid && out1_ready) cnt1_q <= cnt1_q + 16'd1;
    end
  end
  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif
endmodule
